jk_counter: RTL

- Parametrised synchronous modulo-N up/down counter. Each state bit is a JK storage cell.
- Successor to the single-bit JK flip-flop: adds configurable width, modulus, enable, count direction, parallel load and wrap/carry signalling.
- Used as the timing/sequence counter in project datapaths. The registered carry cascades into the enable of the next stage.

---
 rtl/jk_pkg.sv | 29 ++
 rtl/jk_cell.sv | 46 ++++
 rtl/jk_counter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg -- shared definitions for the jk_counter family.
//   * Mode encodings driven on the counter's 2-bit mode port.
//   * RESET_ACTIVE: level of the reset input that holds the block in reset.
//   * jk_drive(): derives the J/K inputs of one storage cell from the wanted
//     next value and the present value of that bit.
// ---------------------------------------------------------------------------
package jk_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic RESET_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    M_HOLD = MODE_HOLD,
    M_UP   = MODE_UP,
    M_DOWN = MODE_DOWN,
    M_LOAD = MODE_LOAD
  } jk_mode_e;

  // Returns {j, k}. Only set/clear/hold are ever produced, never toggle.
  function automatic logic [1:0] jk_drive(input logic n, input logic q);
    return {n & ~q, ~n & q};
  endfunction

endpackage

// File: rtl/jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell -- single-bit JK storage element.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous reset, active level jk_pkg::RESET_ACTIVE (low)
//   j, k   in   00 hold, 10 set, 01 clear, 11 toggle
//   q      out  stored bit
// Parameter RESET_Q selects the value loaded while reset is asserted.
// ---------------------------------------------------------------------------
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RESET_Q = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      2'b00: q_d = q_q;
      2'b10: q_d = 1'b1;
      2'b01: q_d = 1'b0;
      2'b11: q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ACTIVE) begin
      q_q <= RESET_Q;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_counter.sv
// ---------------------------------------------------------------------------
// jk_counter -- modulo-MODULUS up/down counter built from WIDTH jk_cell bits.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   enable      in   advance/load only when 1
//   mode        in   00 hold, 01 up, 10 down, 11 parallel load
//   load_value  in   value captured in load mode (clamped to MODULUS-1)
//   count       out  current count (cell outputs)
//   terminal    out  combinational: about to wrap in the selected direction
//   carry       out  registered one-cycle pulse on each wrap
//   load_error  out  sticky: an out-of-range load was seen since reset
// Build option: define JK_COUNTER_SATURATE_EN to make up/down stop at the
// range ends instead of wrapping (carry then stays 0).
// ---------------------------------------------------------------------------
module jk_counter
  import jk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 10,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             carry,
  output logic             load_error
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("jk_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset_value
      $error("jk_counter: RESET_VALUE must be below MODULUS");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  // One bit wider so MODULUS = 2**WIDTH is representable in the load check.
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

  jk_mode_e         mode_e;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             carry_q;
  logic             carry_d;
  logic             load_error_q;
  logic             load_error_d;
  logic             at_max;
  logic             at_zero;
  logic             load_ok;

  assign mode_e  = jk_mode_e'(mode);
  assign at_max  = (count_q == MAX_COUNT);
  assign at_zero = (count_q == '0);
  assign load_ok = ({1'b0, load_value} < MOD_EXT);

  // Next-state is always formed inside 0..MODULUS-1; the wrap is explicit,
  // so binary overflow at 2**WIDTH never leaks through.
  always_comb begin
    count_d      = count_q;
    carry_d      = 1'b0;
    load_error_d = load_error_q;
    if (enable) begin
      unique case (mode_e)
        M_HOLD: count_d = count_q;
        M_UP: begin
          if (at_max) begin
`ifdef JK_COUNTER_SATURATE_EN
            count_d = count_q;
`else
            count_d = '0;
            carry_d = 1'b1;
`endif
          end else begin
            count_d = count_q + ONE;
          end
        end
        M_DOWN: begin
          if (at_zero) begin
`ifdef JK_COUNTER_SATURATE_EN
            count_d = count_q;
`else
            count_d = MAX_COUNT;
            carry_d = 1'b1;
`endif
          end else begin
            count_d = count_q - ONE;
          end
        end
        M_LOAD: begin
          if (load_ok) begin
            count_d = load_value;
          end else begin
            count_d      = MAX_COUNT;
            load_error_d = 1'b1;
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  // Each bit is a JK cell steered to count_d via set/clear/hold.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] jk;
    assign jk = jk_drive(count_d[i], count_q[i]);
    jk_cell #(
      .RESET_Q(RST_COUNT[i])
    ) u_cell (
      .clock(clock),
      .reset(reset),
      .j    (jk[1]),
      .k    (jk[0]),
      .q    (count_q[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ACTIVE) begin
      carry_q      <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      carry_q      <= carry_d;
      load_error_q <= load_error_d;
    end
  end

  // Terminal looks at mode only, not enable, so a cascade can see it early.
  assign terminal   = ((mode_e == M_UP) && at_max) || ((mode_e == M_DOWN) && at_zero);
  assign count      = count_q;
  assign carry      = carry_q;
  assign load_error = load_error_q;

endmodule
